io_request_handshake: RTL and testbench

//  Sits between the debounced buttons/switches and the processor core. Stalls the core while an

---
 rtl/io_request_handshake.sv | 132 +++++++++++++
 tb/tb_io_request_handshake.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_request_handshake.sv
// Operator handshake for I/O instructions: stalls the core until a fresh button press
// releases the pending input (switch capture) or output instruction.
module io_request_handshake #(
  parameter int IO_WIDTH   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int WAIT_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  is_input,
  input  logic                  is_output,
  input  logic                  confirmation,
  input  logic                  continue_btn,
  input  logic [IO_WIDTH:0]     sw,
  output logic                  hold,
  output logic [DATA_WIDTH-1:0] input_data,
  output logic                  input_valid,
  output logic                  waiting_input,
  output logic                  waiting_output,
  output logic [WAIT_WIDTH-1:0] wait_cycles
);

  typedef enum logic [2:0] {
    IDLE,
    ARM_IN,
    WAIT_IN,
    DONE_IN,
    ARM_OUT,
    WAIT_OUT,
    DONE_OUT
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] sw_ext;
  logic                  in_wait;

  // Switch MSB selects sign extension of the value field; otherwise zero-extend.
  assign sw_ext = sw[IO_WIDTH]
                ? {{(DATA_WIDTH-IO_WIDTH){sw[IO_WIDTH-1]}}, sw[IO_WIDTH-1:0]}
                : {{(DATA_WIDTH-IO_WIDTH){1'b0}}, sw[IO_WIDTH-1:0]};

  assign in_wait        = (state == ARM_IN) || (state == WAIT_IN) ||
                          (state == ARM_OUT) || (state == WAIT_OUT);
  assign waiting_input  = (state == ARM_IN)  || (state == WAIT_IN);
  assign waiting_output = (state == ARM_OUT) || (state == WAIT_OUT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      hold        <= 1'b0;
      input_data  <= '0;
      input_valid <= 1'b0;
      wait_cycles <= '0;
    end else begin
      // NOTE: non-blocking everywhere here; the pulse default is overridden only on capture.
      input_valid <= 1'b0;

      if (in_wait && (wait_cycles != '1))
        wait_cycles <= wait_cycles + WAIT_WIDTH'(1);

      unique case (state)
        IDLE: begin
          if (is_input) begin
            state       <= ARM_IN;
            hold        <= 1'b1;
            wait_cycles <= '0;
          end else if (is_output) begin
            state       <= ARM_OUT;
            hold        <= 1'b1;
            wait_cycles <= '0;
          end
        end

        // A press still held from before the request must be released first.
        ARM_IN: begin
          if (!is_input) begin
            state <= IDLE;
            hold  <= 1'b0;
          end else if (!confirmation) begin
            state <= WAIT_IN;
          end
        end

        WAIT_IN: begin
          if (!is_input) begin
            state <= IDLE;
            hold  <= 1'b0;
          end else if (confirmation) begin
            state       <= DONE_IN;
            hold        <= 1'b0;
            input_data  <= sw_ext;
            input_valid <= 1'b1;
          end
        end

        DONE_IN: begin
          if (!is_input) state <= IDLE;
        end

        ARM_OUT: begin
          if (!is_output) begin
            state <= IDLE;
            hold  <= 1'b0;
          end else if (!continue_btn) begin
            state <= WAIT_OUT;
          end
        end

        WAIT_OUT: begin
          if (!is_output) begin
            state <= IDLE;
            hold  <= 1'b0;
          end else if (continue_btn) begin
            state <= DONE_OUT;
            hold  <= 1'b0;
          end
        end

        DONE_OUT: begin
          if (!is_output) state <= IDLE;
        end

        default: begin
          state <= IDLE;
          hold  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_request_handshake.sv
// Self-checking bench for io_request_handshake: directed scenarios plus random stimulus
// compared every cycle against a transaction-level reference model.
module tb_io_request_handshake;

  localparam int IO_WIDTH   = 16;
  localparam int DATA_WIDTH = 32;
  localparam int WAIT_WIDTH = 16;
  localparam int WAIT_MAX   = (1 << WAIT_WIDTH) - 1;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  is_input;
  logic                  is_output;
  logic                  confirmation;
  logic                  continue_btn;
  logic [IO_WIDTH:0]     sw;
  logic                  hold;
  logic [DATA_WIDTH-1:0] input_data;
  logic                  input_valid;
  logic                  waiting_input;
  logic                  waiting_output;
  logic [WAIT_WIDTH-1:0] wait_cycles;

  always #5 clock = ~clock;

  io_request_handshake #(
    .IO_WIDTH  (IO_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .WAIT_WIDTH(WAIT_WIDTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .is_input      (is_input),
    .is_output     (is_output),
    .confirmation  (confirmation),
    .continue_btn  (continue_btn),
    .sw            (sw),
    .hold          (hold),
    .input_data    (input_data),
    .input_valid   (input_valid),
    .waiting_input (waiting_input),
    .waiting_output(waiting_output),
    .wait_cycles   (wait_cycles)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one pending request (busy) of a given kind, whether the
  // operator has released the button since the request (armed), and whether the
  // current instruction was already served.
  bit          m_busy, m_kind_in, m_armed, m_served;
  bit          m_hold, m_valid;
  logic [31:0] m_data;
  int          m_wc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext_value(input logic [IO_WIDTH:0] s);
    logic [31:0] v;
    v = 32'(s[IO_WIDTH-1:0]);
    if (s[IO_WIDTH] && v >= 32'h8000) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_step();
    bit req, btn;
    if (reset) begin
      m_busy = 0; m_served = 0; m_armed = 0; m_kind_in = 0;
      m_hold = 0; m_valid = 0; m_data = '0; m_wc = 0;
      return;
    end
    m_valid = 0;
    if (m_served) begin
      if (!(m_kind_in ? is_input : is_output)) m_served = 0;
    end else if (!m_busy) begin
      if (is_input || is_output) begin
        m_busy = 1; m_kind_in = is_input; m_armed = 0; m_hold = 1; m_wc = 0;
      end
    end else begin
      req  = m_kind_in ? is_input : is_output;
      btn  = m_kind_in ? confirmation : continue_btn;
      m_wc = (m_wc < WAIT_MAX) ? m_wc + 1 : WAIT_MAX;
      if (!req) begin
        m_busy = 0; m_hold = 0;
      end else if (!m_armed) begin
        if (!btn) m_armed = 1;
      end else if (btn) begin
        m_busy = 0; m_served = 1; m_hold = 0;
        if (m_kind_in) begin
          m_data  = ext_value(sw);
          m_valid = 1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".hold"},           64'(hold),           64'(m_hold));
    check({tag, ".input_valid"},    64'(input_valid),    64'(m_valid));
    check({tag, ".input_data"},     64'(input_data),     64'(m_data));
    check({tag, ".wait_cycles"},    64'(wait_cycles),    64'(m_wc));
    check({tag, ".waiting_input"},  64'(waiting_input),  64'(m_busy && m_kind_in));
    check({tag, ".waiting_output"}, 64'(waiting_output), 64'(m_busy && !m_kind_in));
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    model_step();
    #1;
    compare_all(tag);
  endtask

  initial begin
    reset = 1; is_input = 0; is_output = 0; confirmation = 0; continue_btn = 0;
    sw = '0;
    tick("reset");
    tick("reset");
    check("reset_hold", 64'(hold), 64'd0);
    check("reset_data", 64'(input_data), 64'd0);
    reset = 0;

    // Zero-extended capture on a fresh confirmation press.
    is_input = 1; sw = 17'h0_8001;
    tick("in0_arm");
    check("in0_hold_rise", 64'(hold), 64'd1);
    tick("in0_wait");
    tick("in0_wait");
    tick("in0_wait");
    check("in0_still_hold", 64'(hold), 64'd1);
    confirmation = 1;
    tick("in0_press");
    check("in0_data", 64'(input_data), 64'h0000_8001);
    check("in0_valid", 64'(input_valid), 64'd1);
    check("in0_hold_fall", 64'(hold), 64'd0);
    confirmation = 0;
    tick("in0_done");
    check("in0_valid_pulse", 64'(input_valid), 64'd0);
    is_input = 0;
    tick("in0_idle");

    // Sign-extended capture.
    is_input = 1; sw = 17'h1_8001;
    tick("in1_arm");
    tick("in1_wait");
    confirmation = 1;
    tick("in1_press");
    check("in1_data", 64'(input_data), 64'hFFFF_8001);
    confirmation = 0; is_input = 0;
    tick("in1_done");
    tick("in1_idle");

    // Reset held three cycles in the middle of a wait.
    is_input = 1;
    tick("rst_arm");
    tick("rst_wait");
    reset = 1;
    tick("rst_hold");
    tick("rst_hold");
    tick("rst_hold");
    check("rst_mid_hold", 64'(hold), 64'd0);
    check("rst_mid_data", 64'(input_data), 64'd0);
    check("rst_mid_waiting", 64'(waiting_input), 64'd0);
    reset = 0; is_input = 0;
    tick("rst_idle");

    // Confirmation already held before the request: must be released first.
    confirmation = 1; sw = 17'h0_1234;
    tick("stale_idle");
    is_input = 1;
    tick("stale_arm");
    tick("stale_arm");
    tick("stale_arm");
    tick("stale_arm");
    check("stale_no_capture", 64'(input_valid), 64'd0);
    check("stale_hold", 64'(hold), 64'd1);
    confirmation = 0;
    tick("stale_release");
    confirmation = 1;
    tick("stale_press");
    check("stale_wait_cycles", 64'(wait_cycles), 64'd5);
    check("stale_data", 64'(input_data), 64'h0000_1234);
    confirmation = 0; is_input = 0;
    tick("stale_done");
    tick("stale_idle2");

    // Output path: confirmation ignored, continue releases, no re-arm while held.
    is_output = 1;
    tick("out_arm");
    tick("out_wait");
    confirmation = 1;
    tick("out_conf");
    check("out_conf_ignored", 64'(hold), 64'd1);
    confirmation = 0; continue_btn = 1;
    tick("out_press");
    check("out_hold_fall", 64'(hold), 64'd0);
    check("out_no_valid", 64'(input_valid), 64'd0);
    check("out_data_kept", 64'(input_data), 64'h0000_1234);
    continue_btn = 0;
    for (int i = 0; i < 5; i++) begin
      tick("out_done");
      check("out_no_rearm", 64'(waiting_output), 64'd0);
    end
    is_output = 0;
    tick("out_idle");

    // Both requests together: input wins; long wait saturates the counter.
    is_input = 1; is_output = 1;
    tick("both_arm");
    check("both_input_wins", 64'(waiting_input), 64'd1);
    check("both_not_output", 64'(waiting_output), 64'd0);
    for (int i = 0; i < WAIT_MAX + 5; i++) tick("sat");
    check("sat_value", 64'(wait_cycles), 64'hFFFF);
    is_input = 0; is_output = 0;
    tick("abort");
    check("abort_hold", 64'(hold), 64'd0);
    tick("abort_idle");

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) is_input  = ~is_input;
      if ($urandom_range(0, 15) == 0) is_output = ~is_output;
      confirmation = ($urandom_range(0, 3) == 0);
      continue_btn = ($urandom_range(0, 3) == 0);
      sw           = 17'($urandom);
      reset        = ($urandom_range(0, 199) == 0);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
